// File: rtl/icache_bank_resp_arbiter.sv
// Bank-side icache arbiter: round-robin selection of fetch ports onto one bank port,
// in-order ID FIFO for outstanding bank reads, one-hot registered response steering.
module icache_bank_resp_arbiter #(
    parameter int N_FETCH      = 8,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_OUTSTAND = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [N_FETCH-1:0]              fetch_req_i,
    input  logic [N_FETCH*ADDR_WIDTH-1:0]   fetch_addr_i,
    output logic [N_FETCH-1:0]              fetch_gnt_o,
    output logic [N_FETCH-1:0]              fetch_rvalid_o,
    output logic [DATA_WIDTH-1:0]           fetch_rdata_o,
    output logic                            bank_req_o,
    output logic [ADDR_WIDTH-1:0]           bank_addr_o,
    input  logic                            bank_gnt_i,
    input  logic                            bank_rvalid_i,
    input  logic [DATA_WIDTH-1:0]           bank_rdata_i,
    output logic [$clog2(MAX_OUTSTAND):0]   outstanding_o,
    output logic                            err_o
);

    localparam int IDW = $clog2(N_FETCH);
    localparam int PW  = $clog2(MAX_OUTSTAND);
    localparam int CW  = PW + 1;

    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]        id_mem_q [MAX_OUTSTAND];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [N_FETCH-1:0]    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [IDW-1:0]        winner;
    logic                  found;
    int                    idx;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [IDW-1:0]        head;

    assign full  = (count_q == CW'(MAX_OUTSTAND));
    assign empty = (count_q == '0);
    assign head  = id_mem_q[rd_ptr_q];

    // Round-robin scan starting at rr_ptr_q with wrap-around; first requester wins
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N_FETCH; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_FETCH) idx = idx - N_FETCH;
            if (!found && fetch_req_i[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    assign bank_req_o  = found & ~full;
    assign bank_addr_o = found ? fetch_addr_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign push        = bank_req_o & bank_gnt_i;
    assign pop         = bank_rvalid_i & ~empty;

    // One-hot grant to the winner only when the bank takes the request
    always_comb begin
        fetch_gnt_o = '0;
        if (push) fetch_gnt_o[winner] = 1'b1;
    end

    // Next-state for pointer, FIFO bookkeeping and response registers
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            if (int'(winner) == N_FETCH - 1) rr_ptr_d = '0;
            else                             rr_ptr_d = winner + IDW'(1);
        end
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        rvalid_d = pop ? (N_FETCH'(1) << head) : '0;
        rdata_d  = pop ? bank_rdata_i : rdata_q;
        err_d    = err_q | (bank_rvalid_i & empty);
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // ID storage needs no reset: entries are only read when count_q says they are valid
    always_ff @(posedge clk_i) begin
        if (push) id_mem_q[wr_ptr_q] <= winner;
    end

    assign fetch_rvalid_o = rvalid_q;
    assign fetch_rdata_o  = rdata_q;
    assign outstanding_o  = count_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_icache_bank_resp_arbiter.sv
// Self-checking bench for icache_bank_resp_arbiter; the bench plays the bank and keeps a
// queue of expected in-flight port IDs that is popped when the bank returns data.
module tb_icache_bank_resp_arbiter;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [7:0]   fetch_req_i = '0;
    logic [255:0] fetch_addr_i;
    logic [7:0]   fetch_gnt_o;
    logic [7:0]   fetch_rvalid_o;
    logic [31:0]  fetch_rdata_o;
    logic         bank_req_o;
    logic [31:0]  bank_addr_o;
    logic         bank_gnt_i = 1'b0;
    logic         bank_rvalid_i = 1'b0;
    logic [31:0]  bank_rdata_i = '0;
    logic [2:0]   outstanding_o;
    logic         err_o;

    int           n_checks = 0;
    int           n_errors = 0;
    int           id_q[$];
    logic         err_exp = 1'b0;
    logic [31:0]  last_rdata = '0;

    icache_bank_resp_arbiter #(
        .N_FETCH(8), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTAND(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
        .fetch_gnt_o(fetch_gnt_o), .fetch_rvalid_o(fetch_rvalid_o),
        .fetch_rdata_o(fetch_rdata_o), .bank_req_o(bank_req_o),
        .bank_addr_o(bank_addr_o), .bank_gnt_i(bank_gnt_i),
        .bank_rvalid_i(bank_rvalid_i), .bank_rdata_i(bank_rdata_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] addr_of(input int p);
        return 32'hA000_0000 + 32'(p * 16);
    endfunction

    // One bank cycle: drive, check combinational outputs, update scoreboard, check registered
    // outputs after the edge. win = expected arbitration winner, -1 when nothing requests.
    task automatic step(input logic [7:0] req, input logic bg, input logic rv,
                        input logic [31:0] rd, input int win);
        logic       exp_req;
        logic [7:0] exp_gnt;
        logic       exp_rv;
        int         port;
        @(negedge clk_i);
        fetch_req_i   = req;
        bank_gnt_i    = bg;
        bank_rvalid_i = rv;
        bank_rdata_i  = rd;
        #1;
        exp_req = (req != 8'h00) && (id_q.size() < 4);
        exp_gnt = (exp_req && bg) ? (8'h01 << win) : 8'h00;
        chk("bank_req", 32'(bank_req_o), 32'(exp_req));
        chk("fetch_gnt", 32'(fetch_gnt_o), 32'(exp_gnt));
        chk("bank_addr", bank_addr_o, (win < 0) ? 32'h0 : addr_of(win));
        exp_rv = 1'b0;
        port   = 0;
        if (rv) begin
            if (id_q.size() > 0) begin
                port   = id_q.pop_front();
                exp_rv = 1'b1;
            end else begin
                err_exp = 1'b1;
            end
        end
        if (exp_gnt != 8'h00) id_q.push_back(win);
        @(posedge clk_i);
        #1;
        chk("fetch_rvalid", 32'(fetch_rvalid_o), exp_rv ? 32'(8'h01 << port) : 32'h0);
        if (exp_rv) last_rdata = rd;
        chk("fetch_rdata", fetch_rdata_o, last_rdata);
        chk("outstanding", 32'(outstanding_o), 32'(id_q.size()));
        chk("err", 32'(err_o), 32'(err_exp));
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i         = 1'b1;
        fetch_req_i   = '0;
        bank_gnt_i    = 1'b0;
        bank_rvalid_i = 1'b0;
        @(posedge clk_i);
        #1;
        id_q.delete();
        err_exp    = 1'b0;
        last_rdata = '0;
        chk("rst_outstanding", 32'(outstanding_o), 32'h0);
        chk("rst_rvalid", 32'(fetch_rvalid_o), 32'h0);
        chk("rst_rdata", fetch_rdata_o, 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) fetch_addr_i[i*32 +: 32] = addr_of(i);

        do_reset();
        chk("rst_bank_req", 32'(bank_req_o), 32'h0);

        // single requester on port 3
        step(8'h08, 1'b1, 1'b0, 32'h0, 3);
        step(8'h00, 1'b0, 1'b0, 32'h0, -1);
        step(8'h00, 1'b0, 1'b1, 32'hCAFE_0003, -1);
        step(8'h00, 1'b0, 1'b0, 32'h0, -1);

        // round-robin over ports 0,2,5 with overlapping returns
        do_reset();
        step(8'h25, 1'b1, 1'b0, 32'h0, 0);
        step(8'h25, 1'b1, 1'b0, 32'h0, 2);
        step(8'h25, 1'b1, 1'b1, 32'hD000_0000, 5);
        step(8'h25, 1'b1, 1'b1, 32'hD000_0001, 0);
        step(8'h25, 1'b1, 1'b1, 32'hD000_0002, 2);
        step(8'h25, 1'b1, 1'b1, 32'hD000_0003, 5);
        step(8'h00, 1'b0, 1'b1, 32'hD000_0004, -1);
        step(8'h00, 1'b0, 1'b1, 32'hD000_0005, -1);

        // back-pressure on port 1
        for (int c = 0; c < 3; c++) step(8'h02, 1'b0, 1'b0, 32'h0, 1);
        step(8'h02, 1'b1, 1'b0, 32'h0, 1);
        step(8'h00, 1'b0, 1'b1, 32'hB000_0001, -1);

        // fill to 4, blocked request, pop does not unblock same cycle
        step(8'h0F, 1'b1, 1'b0, 32'h0, 2);
        step(8'h0F, 1'b1, 1'b0, 32'h0, 3);
        step(8'h0F, 1'b1, 1'b0, 32'h0, 0);
        step(8'h0F, 1'b1, 1'b0, 32'h0, 1);
        step(8'h0F, 1'b1, 1'b0, 32'h0, 2);
        step(8'h0F, 1'b1, 1'b1, 32'hE000_0000, 2);
        step(8'h0F, 1'b1, 1'b0, 32'h0, 2);
        for (int c = 0; c < 4; c++) step(8'h00, 1'b0, 1'b1, 32'hE000_0001 + 32'(c), -1);

        // spurious return sets sticky error
        step(8'h00, 1'b0, 1'b1, 32'hBAD0_BAD0, -1);
        step(8'h00, 1'b0, 1'b0, 32'h0, -1);
        step(8'h00, 1'b0, 1'b0, 32'h0, -1);

        // reset with 3 in flight drops everything
        do_reset();
        for (int c = 0; c < 3; c++) step(8'h08, 1'b1, 1'b0, 32'h0, 3);
        do_reset();
        step(8'h00, 1'b0, 1'b0, 32'h0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
